spi_master_mcs: RTL and testbench

Next-generation SPI master for the kv260/zybo interface fabric. It supports:

- Runtime-selectable SPI mode and transfer length (1..MAX_BITS).
- NUM_CS owned chip-selects with programmable setup and hold.
- A programmable MISO sample delay, generated internally from the capture edge, which compensates board and isolator round-trip.

It sits between the register/AXI-side command logic and the external ADC/DAC SPI pins. It replaces per-device masters with a single shared engine.

---
 rtl/spi_master_mcs.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_master_mcs.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_mcs.sv
// Shared SPI master: runtime mode/length, NUM_CS owned chip-selects with setup/hold,
// and a programmable MISO sample delay that compensates board round-trip.
module spi_master_mcs #(
    parameter int NUM_CS            = 4,
    parameter int MAX_BITS          = 32,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_SETUP_CLKS     = 2,
    parameter int CS_HOLD_CLKS      = 2,
    parameter int MAX_SAMPLE_DLY    = 7,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int DLY_W = (MAX_SAMPLE_DLY > 0) ? $clog2(MAX_SAMPLE_DLY + 1) : 1
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic [1:0]          i_Mode,
    input  logic [6:0]          i_Bit_Len,
    input  logic [CS_W-1:0]     i_CS_Sel,
    input  logic [DLY_W-1:0]    i_Sample_Dly,
    input  logic [MAX_BITS-1:0] i_TX_Data,
    input  logic                i_TX_DV,
    output logic                o_TX_Ready,
    output logic [MAX_BITS-1:0] o_RX_Data,
    output logic                o_RX_DV,
    output logic                o_SPI_Clk,
    output logic                o_SPI_MOSI,
    input  logic                i_SPI_MISO,
    output logic [NUM_CS-1:0]   o_SPI_CS_n
);

    localparam int DLY_DEPTH = (MAX_SAMPLE_DLY > 0) ? MAX_SAMPLE_DLY : 1;
    localparam int CNT_W     = 16;

    localparam logic [6:0]       MAX_LEN    = 7'(MAX_BITS);
    localparam logic [CS_W-1:0]  LAST_CS    = CS_W'(NUM_CS - 1);
    localparam logic [DLY_W-1:0] MAX_DLY    = DLY_W'(MAX_SAMPLE_DLY);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        DRAIN,
        CS_HOLD
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [CNT_W-1:0]    r_cnt;
    logic                r_cpha;
    logic [6:0]          r_bitLen;
    logic [DLY_W-1:0]    r_dly;
    logic [MAX_BITS-1:0] r_txShift;
    logic [6:0]          r_txLeft;
    logic                r_mosi;
    logic                r_spiClk;
    logic [7:0]          r_edgeCnt;
    logic                r_capStrobe;
    logic [DLY_DEPTH-1:0] r_dlyLine;
    logic [MAX_BITS-1:0] r_rxShift;
    logic [6:0]          r_sampCnt;
    logic [NUM_CS-1:0]   r_csN;
    logic                r_txReady;
    logic                r_rxDV;
    logic [MAX_BITS-1:0] r_rxData;

    logic [6:0]          w_effLen;
    logic [CS_W-1:0]     w_effSel;
    logic [DLY_W-1:0]    w_effDly;
    logic [MAX_BITS-1:0] w_txAligned;
    logic                w_accept;
    logic [DLY_DEPTH:0]  w_taps;
    logic                w_sampleNow;
    logic                w_sampDone;
    logic                w_edgesDone;
    logic                w_toggle;
    logic                w_leading;
    logic                w_capEdge;
    logic                w_launch;
    logic                w_finish;

    // Request decode: clamp out-of-range fields and left-align TX so the MSB is bit L-1.
    always_comb begin
        w_effLen = i_Bit_Len;
        if ((i_Bit_Len == 7'd0) || (i_Bit_Len > MAX_LEN)) begin
            w_effLen = MAX_LEN;
        end
        w_effSel = (i_CS_Sel > LAST_CS) ? LAST_CS : i_CS_Sel;
        w_effDly = (i_Sample_Dly > MAX_DLY) ? MAX_DLY : i_Sample_Dly;
        w_txAligned = i_TX_Data << (MAX_LEN - w_effLen);
        w_accept = (r_state == IDLE) && i_TX_DV && r_txReady;
    end

    // Tap 0 is the undelayed strobe, which samples in the cycle SCLK shows the capture edge.
    always_comb begin
        w_taps      = {r_dlyLine, r_capStrobe};
        w_sampleNow = w_taps[r_dly] && ((r_state == SHIFT) || (r_state == DRAIN)) &&
                      (r_sampCnt != r_bitLen);
        w_sampDone  = (r_sampCnt == r_bitLen) ||
                      (w_sampleNow && ((r_sampCnt + 7'd1) == r_bitLen));
        w_edgesDone = (r_edgeCnt == {r_bitLen, 1'b0});
        w_toggle    = (r_state == SHIFT) && !w_edgesDone && (r_cnt == HALF_LAST);
        w_leading   = ~r_edgeCnt[0];
        w_capEdge   = w_toggle && (w_leading ^ r_cpha);
        w_launch    = w_toggle && !(w_leading ^ r_cpha) && (r_txLeft != 7'd0);
        w_finish    = (r_state == CS_HOLD) && (r_cnt == HOLD_LAST);
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_nextState = CS_SETUP;
            CS_SETUP: if (r_cnt == SETUP_LAST) w_nextState = SHIFT;
            SHIFT:    if (w_edgesDone) w_nextState = w_sampDone ? CS_HOLD : DRAIN;
            DRAIN:    if (w_sampDone) w_nextState = CS_HOLD;
            CS_HOLD:  if (w_finish) w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Shared phase counter: restarts on every state change and on every SCLK edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_cnt <= '0;
        end else if ((w_nextState != r_state) || w_toggle) begin
            r_cnt <= '0;
        end else if (r_state != IDLE) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_cpha   <= 1'b0;
            r_bitLen <= '0;
            r_dly    <= '0;
        end else if (w_accept) begin
            r_cpha   <= i_Mode[0];
            r_bitLen <= w_effLen;
            r_dly    <= w_effDly;
        end
    end

    // CPHA=0 puts the first bit on MOSI at accept; CPHA=1 waits for the first leading edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_txShift <= '0;
            r_txLeft  <= '0;
            r_mosi    <= 1'b0;
        end else if (w_accept) begin
            if (i_Mode[0]) begin
                r_txShift <= w_txAligned;
                r_txLeft  <= w_effLen;
            end else begin
                r_mosi    <= w_txAligned[MAX_BITS-1];
                r_txShift <= w_txAligned << 1;
                r_txLeft  <= w_effLen - 7'd1;
            end
        end else if (w_launch) begin
            r_mosi    <= r_txShift[MAX_BITS-1];
            r_txShift <= r_txShift << 1;
            r_txLeft  <= r_txLeft - 7'd1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_spiClk  <= 1'b0;
            r_edgeCnt <= '0;
        end else if (w_accept) begin
            r_spiClk  <= i_Mode[1];
            r_edgeCnt <= '0;
        end else if (w_toggle) begin
            r_spiClk  <= ~r_spiClk;
            r_edgeCnt <= r_edgeCnt + 8'd1;
        end
    end

    // Capture strobes march down the delay line independently, so several may be in flight.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_capStrobe <= 1'b0;
            r_dlyLine   <= '0;
            r_rxShift   <= '0;
            r_sampCnt   <= '0;
        end else begin
            r_capStrobe <= w_capEdge;
            r_dlyLine   <= (r_dlyLine << 1) | DLY_DEPTH'(r_capStrobe);
            if (w_accept) begin
                r_rxShift <= '0;
                r_sampCnt <= '0;
            end else if (w_sampleNow) begin
                r_rxShift <= {r_rxShift[MAX_BITS-2:0], i_SPI_MISO};
                r_sampCnt <= r_sampCnt + 7'd1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_csN     <= '1;
            r_txReady <= 1'b0;
            r_rxDV    <= 1'b0;
            r_rxData  <= '0;
        end else begin
            r_txReady <= (w_nextState == IDLE);
            r_rxDV    <= w_finish;
            if (w_accept) begin
                r_csN <= ~(NUM_CS'(1) << w_effSel);
            end else if (w_finish) begin
                r_csN    <= '1;
                r_rxData <= r_rxShift;
            end
        end
    end

    assign o_TX_Ready = r_txReady;
    assign o_RX_Data  = r_rxData;
    assign o_RX_DV    = r_rxDV;
    assign o_SPI_Clk  = r_spiClk;
    assign o_SPI_MOSI = r_mosi;
    assign o_SPI_CS_n = r_csN;

endmodule

// File: tb/tb_spi_master_mcs.sv
// Bench for spi_master_mcs: vector table through a mode-aware SPI slave model with
// configurable MISO lag, a receive scoreboard, and hand-written abort/back-to-back cases.
module tb_spi_master_mcs;

    logic        clock;
    logic        resetL;
    logic [1:0]  i_Mode;
    logic [6:0]  i_Bit_Len;
    logic [1:0]  i_CS_Sel;
    logic [2:0]  i_Sample_Dly;
    logic [31:0] i_TX_Data;
    logic        i_TX_DV;
    logic        o_TX_Ready;
    logic [31:0] o_RX_Data;
    logic        o_RX_DV;
    logic        o_SPI_Clk;
    logic        o_SPI_MOSI;
    logic        i_SPI_MISO;
    logic [3:0]  o_SPI_CS_n;

    spi_master_mcs dut (
        .i_Clk        (clock),
        .i_Rst_L      (resetL),
        .i_Mode       (i_Mode),
        .i_Bit_Len    (i_Bit_Len),
        .i_CS_Sel     (i_CS_Sel),
        .i_Sample_Dly (i_Sample_Dly),
        .i_TX_Data    (i_TX_Data),
        .i_TX_DV      (i_TX_DV),
        .o_TX_Ready   (o_TX_Ready),
        .o_RX_Data    (o_RX_Data),
        .o_RX_DV      (o_RX_DV),
        .o_SPI_Clk    (o_SPI_Clk),
        .o_SPI_MOSI   (o_SPI_MOSI),
        .i_SPI_MISO   (i_SPI_MISO),
        .o_SPI_CS_n   (o_SPI_CS_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  mode;
        logic [6:0]  len;
        logic [1:0]  sel;
        logic [2:0]  dly;
        logic [31:0] tx;
        bit          loopback;
        logic [31:0] slvData;
        int          lag;
        logic [31:0] expRx;
        bit          mustMatch;
        int          expEdges;
        int          expCsLow;
        logic [3:0]  expCs;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        bit          mustMatch;
    } sb_t;

    sb_t  sbQ[$];
    vec_t vecs[8];

    int passCnt = 0;
    int checkCnt = 0;

    int         cycleCnt = 0;
    int         csLowCnt = 0;
    int         edgeTotal = 0;
    int         dvCount = 0;
    int         dvCycle = -1;
    int         dvBase = 0;
    bit         multiLow = 1'b0;
    logic [3:0] lastCs = 4'hF;
    bit         prevCsLow = 1'b0;
    logic       prevClk = 1'b0;

    bit          slvLoop = 1'b1;
    bit          slvCpha = 1'b0;
    int          slvLen = 8;
    int          slvLag = 0;
    logic [31:0] slvData = '0;
    int          sEdges = 0;
    int          slvIdx = 0;
    logic        slvRaw;
    logic [7:0]  slvHist = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCnt++;
        if (actual === expected) passCnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic checkDiffers(input string name, input logic [63:0] actual, input logic [63:0] avoided);
        checkCnt++;
        if (actual !== avoided) passCnt++;
        else $display("[TB] FAIL %s: got 0x%0h, required anything but 0x%0h", name, actual, avoided);
    endtask

    task automatic timeoutFail(input string name);
        checkCnt++;
        $display("[TB] FAIL %s: timed out, got no event, expected one", name);
    endtask

    // Mid-cycle observer: slave model, CS/SCLK statistics and RX scoreboard.
    always @(negedge clock) begin
        cycleCnt++;
        if (o_SPI_CS_n != 4'hF) begin
            csLowCnt++;
            lastCs = o_SPI_CS_n;
            if ($countones(~o_SPI_CS_n) != 1) multiLow = 1'b1;
            if (prevCsLow && (o_SPI_Clk != prevClk)) begin
                sEdges++;
                edgeTotal++;
            end
            prevCsLow = 1'b1;
        end else begin
            sEdges = 0;
            prevCsLow = 1'b0;
        end
        prevClk = o_SPI_Clk;

        if (slvLoop) begin
            slvRaw = o_SPI_MOSI;
        end else begin
            if (slvCpha) slvIdx = (sEdges == 0) ? slvLen - 1 : slvLen - 1 - (sEdges - 1) / 2;
            else         slvIdx = slvLen - 1 - sEdges / 2;
            slvRaw = (slvIdx >= 0 && slvIdx < slvLen) ? slvData[slvIdx] : 1'b0;
        end
        slvHist = {slvHist[6:0], slvRaw};
        i_SPI_MISO = slvHist[slvLag];

        if (o_RX_DV) begin
            sb_t e;
            dvCount++;
            dvCycle = cycleCnt;
            if (sbQ.size() == 0) begin
                timeoutFail("unexpected_rx_dv");
            end else begin
                e = sbQ.pop_front();
                if (e.mustMatch) checkOutput("rx_data", 64'(o_RX_Data), 64'(e.data));
                else             checkDiffers("rx_data_corrupt", 64'(o_RX_Data), 64'(e.data));
            end
        end
    end

    task automatic waitReady(input string name);
        for (int i = 0; i < 5000; i++) begin
            @(posedge clock);
            #1;
            if (o_TX_Ready) break;
        end
        if (!o_TX_Ready) timeoutFail(name);
    endtask

    task automatic startTransfer(input vec_t v);
        waitReady("wait_ready");
        i_Mode       = v.mode;
        i_Bit_Len    = v.len;
        i_CS_Sel     = v.sel;
        i_Sample_Dly = v.dly;
        i_TX_Data    = v.tx;
        slvLoop      = v.loopback;
        slvCpha      = v.mode[0];
        slvLen       = (v.len == 7'd0) ? 32 : int'(v.len);
        slvLag       = v.lag;
        slvData      = v.slvData;
        cycleCnt     = -1;
        csLowCnt     = 0;
        edgeTotal    = 0;
        multiLow     = 1'b0;
        lastCs       = 4'hF;
        dvBase       = dvCount;
        sbQ.push_back('{data: v.expRx, mustMatch: v.mustMatch});
        i_TX_DV      = 1'b1;
        @(posedge clock);
        #1;
        i_TX_DV      = 1'b0;
    endtask

    task automatic waitRxDv(input string name, input int target);
        for (int i = 0; i < 5000; i++) begin
            @(posedge clock);
            if (dvCount >= target) break;
        end
        if (dvCount < target) timeoutFail(name);
    endtask

    task automatic applyStimulus(input vec_t v);
        startTransfer(v);
        waitRxDv("rx_dv_timeout", dvBase + 1);
        checkOutput("sclk_edges", 64'(edgeTotal), 64'(v.expEdges));
        checkOutput("cs_low_cycles", 64'(csLowCnt), 64'(v.expCsLow));
        checkOutput("rx_dv_cycle", 64'(dvCycle), 64'(v.expCsLow + 1));
        checkOutput("cs_select", 64'(lastCs), 64'(v.expCs));
        checkOutput("cs_one_hot", 64'(multiLow), 64'(0));
        #1;
        checkOutput("sclk_idle_cpol", 64'(o_SPI_Clk), 64'(v.mode[1]));
        checkOutput("cs_idle_high", 64'(o_SPI_CS_n), 64'(4'hF));
    endtask

    initial begin
        vec_t v;
        int   base;

        vecs[0] = '{2'd0, 7'd8,  2'd1, 3'd0, 32'h0000_00A5, 1'b1, 32'h0,       0, 32'h0000_00A5, 1'b1, 16, 37,  4'b1101};
        vecs[1] = '{2'd0, 7'd18, 2'd0, 3'd0, 32'h0002_AAAB, 1'b0, 32'h1_5555,  0, 32'h0001_5555, 1'b1, 36, 77,  4'b1110};
        vecs[2] = '{2'd1, 7'd18, 2'd2, 3'd0, 32'h0002_AAAB, 1'b0, 32'h1_5555,  0, 32'h0001_5555, 1'b1, 36, 77,  4'b1011};
        vecs[3] = '{2'd2, 7'd18, 2'd3, 3'd0, 32'h0002_AAAB, 1'b0, 32'h1_5555,  0, 32'h0001_5555, 1'b1, 36, 77,  4'b0111};
        vecs[4] = '{2'd3, 7'd18, 2'd1, 3'd0, 32'h0002_AAAB, 1'b0, 32'h1_5555,  0, 32'h0001_5555, 1'b1, 36, 77,  4'b1101};
        vecs[5] = '{2'd1, 7'd8,  2'd0, 3'd0, 32'h0,         1'b0, 32'h3C,      3, 32'h0000_003C, 1'b0, 16, 37,  4'b1110};
        vecs[6] = '{2'd1, 7'd8,  2'd0, 3'd3, 32'h0,         1'b0, 32'h3C,      3, 32'h0000_003C, 1'b1, 16, 40,  4'b1110};
        vecs[7] = '{2'd0, 7'd0,  2'd3, 3'd0, 32'hDEAD_BEEF, 1'b1, 32'h0,       0, 32'hDEAD_BEEF, 1'b1, 64, 133, 4'b0111};

        resetL       = 1'b1;
        i_Mode       = '0;
        i_Bit_Len    = '0;
        i_CS_Sel     = '0;
        i_Sample_Dly = '0;
        i_TX_Data    = '0;
        i_TX_DV      = 1'b0;
        i_SPI_MISO   = 1'b0;
        #2 resetL = 1'b0;
        #1;
        checkOutput("rst_tx_ready", 64'(o_TX_Ready), 64'(0));
        checkOutput("rst_rx_dv", 64'(o_RX_DV), 64'(0));
        checkOutput("rst_rx_data", 64'(o_RX_Data), 64'(0));
        checkOutput("rst_sclk", 64'(o_SPI_Clk), 64'(0));
        checkOutput("rst_mosi", 64'(o_SPI_MOSI), 64'(0));
        checkOutput("rst_cs_n", 64'(o_SPI_CS_n), 64'(4'hF));
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetL = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("ready_after_release", 64'(o_TX_Ready), 64'(1));

        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d: mode %0d len %0d dly %0d", i, vecs[i].mode, vecs[i].len, vecs[i].dly);
            applyStimulus(vecs[i]);
        end

        // Busy pulse must be dropped; a request in the cycle ready rises must be taken.
        v = '{2'd0, 7'd8, 2'd2, 3'd0, 32'h5A, 1'b1, 32'h0, 0, 32'h5A, 1'b1, 16, 37, 4'b1011};
        startTransfer(v);
        base = dvBase;
        repeat (10) @(posedge clock);
        #1;
        checkOutput("busy_not_ready", 64'(o_TX_Ready), 64'(0));
        i_TX_Data = 32'h33;
        i_TX_DV   = 1'b1;
        @(posedge clock);
        #1;
        i_TX_DV   = 1'b0;
        waitReady("b2b_wait_ready");
        checkOutput("b2b_gap_cs_high", 64'(o_SPI_CS_n), 64'(4'hF));
        i_TX_Data = 32'hC3;
        sbQ.push_back('{data: 32'hC3, mustMatch: 1'b1});
        i_TX_DV   = 1'b1;
        @(posedge clock);
        #1;
        i_TX_DV   = 1'b0;
        checkOutput("b2b_cs_low_again", 64'(o_SPI_CS_n), 64'(4'b1011));
        checkOutput("b2b_not_ready", 64'(o_TX_Ready), 64'(0));
        waitRxDv("b2b_rx_dv_timeout", base + 2);
        repeat (5) @(posedge clock);
        checkOutput("b2b_dv_count", 64'(dvCount - base), 64'(2));

        // Reset in the middle of a transfer aborts it without an RX strobe.
        v = '{2'd0, 7'd8, 2'd1, 3'd0, 32'h96, 1'b1, 32'h0, 0, 32'h96, 1'b1, 16, 37, 4'b1101};
        startTransfer(v);
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            if (edgeTotal >= 5) break;
        end
        if (edgeTotal < 5) timeoutFail("abort_wait_edge5");
        resetL = 1'b0;
        #1;
        checkOutput("abort_cs_n", 64'(o_SPI_CS_n), 64'(4'hF));
        checkOutput("abort_sclk", 64'(o_SPI_Clk), 64'(0));
        checkOutput("abort_mosi", 64'(o_SPI_MOSI), 64'(0));
        checkOutput("abort_tx_ready", 64'(o_TX_Ready), 64'(0));
        checkOutput("abort_rx_dv", 64'(o_RX_DV), 64'(0));
        checkOutput("abort_rx_data", 64'(o_RX_Data), 64'(0));
        sbQ.delete();
        base = dvCount;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetL = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("abort_ready_after_release", 64'(o_TX_Ready), 64'(1));
        repeat (50) @(posedge clock);
        checkOutput("abort_no_rx_dv", 64'(dvCount - base), 64'(0));
        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'(0));

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
